// File: rtl/rob_commit_ctrl.sv
// Reorder buffer: in-order tag allocation, CDB result capture, in-order retirement with mispredict flush.
// Commit outputs are registered one edge after the head is done; allocation is throttled by alloc_ok (full or flushing).
module rob_commit_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alloc_req,
    input  logic        alloc_we,
    input  logic [4:0]  alloc_rd,
    output logic        alloc_ok,
    output logic [7:0]  alloc_tag,
    input  logic        cdb_valid,
    input  logic [7:0]  cdb_tag,
    input  logic [31:0] cdb_data,
    input  logic        cdb_miss,
    input  logic [31:0] cdb_target,
    input  logic [7:0]  q1_tag,
    input  logic [7:0]  q2_tag,
    output logic        q1_ready,
    output logic        q2_ready,
    output logic [31:0] q1_data,
    output logic [31:0] q2_data,
    output logic        ROB_we,
    output logic [4:0]  reg_addr,
    output logic [31:0] reg_data,
    output logic [7:0]  reg_tag,
    output logic        br,
    output logic [31:0] br_target
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);
    localparam logic [7:0]    DEPTH_T = 8'(DEPTH);

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        miss;
        logic [31:0] target;
    } entry_t;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] done_q;
    entry_t           ent_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic        rob_we_q;
    logic [4:0]  reg_addr_q;
    logic [31:0] reg_data_q;
    logic [7:0]  reg_tag_q;
    logic        br_q;
    logic [31:0] br_target_q;

    logic          commit, flush, alloc_fire, cdb_hit, q1_hit, q2_hit;
    logic [PW-1:0] cdb_idx, q1_idx, q2_idx;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    function automatic logic tag_ok(input logic [7:0] t);
        return (t != 8'd0) && (t <= DEPTH_T);
    endfunction

    function automatic logic [PW-1:0] tag_idx(input logic [7:0] t);
        logic [7:0] i;
        i = t - 8'd1;
        return i[PW-1:0];
    endfunction

    assign commit     = valid_q[head_q] && done_q[head_q];
    assign flush      = commit && ent_q[head_q].miss;
    // A slot freed by this cycle's commit is only reusable next cycle, so compare the registered count.
    assign alloc_ok   = (count_q < DEPTH_C) && !flush;
    assign alloc_fire = alloc_req && alloc_ok;
    assign alloc_tag  = 8'(tail_q) + 8'd1;

    assign cdb_idx = tag_idx(cdb_tag);
    assign cdb_hit = cdb_valid && tag_ok(cdb_tag) && valid_q[cdb_idx];

    assign q1_idx   = tag_idx(q1_tag);
    assign q1_hit   = tag_ok(q1_tag) && valid_q[q1_idx];
    assign q1_ready = q1_hit && done_q[q1_idx];
    assign q1_data  = q1_hit ? ent_q[q1_idx].data : '0;

    assign q2_idx   = tag_idx(q2_tag);
    assign q2_hit   = tag_ok(q2_tag) && valid_q[q2_idx];
    assign q2_ready = q2_hit && done_q[q2_idx];
    assign q2_data  = q2_hit ? ent_q[q2_idx].data : '0;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (commit) begin
                head_d = ptr_inc(head_q);
            end
            if (alloc_fire) begin
                tail_d = ptr_inc(tail_q);
            end
            if (alloc_fire && !commit) begin
                count_d = count_q + CW'(1);
            end else if (commit && !alloc_fire) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= '0;
            done_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            rob_we_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_data_q  <= '0;
            reg_tag_q   <= '0;
            br_q        <= 1'b0;
            br_target_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            rob_we_q <= 1'b0;
            br_q     <= 1'b0;

            // A flushing branch still retires its own register write (e.g. jal link).
            if (commit) begin
                rob_we_q   <= ent_q[head_q].we && (ent_q[head_q].rd != 5'd0);
                reg_addr_q <= ent_q[head_q].rd;
                reg_data_q <= ent_q[head_q].data;
                reg_tag_q  <= 8'(head_q) + 8'd1;
            end

            if (flush) begin
                br_q        <= 1'b1;
                br_target_q <= ent_q[head_q].target;
                valid_q     <= '0;
            end else begin
                if (commit) begin
                    valid_q[head_q] <= 1'b0;
                end
                if (cdb_hit) begin
                    done_q[cdb_idx]        <= 1'b1;
                    ent_q[cdb_idx].data   <= cdb_data;
                    ent_q[cdb_idx].miss   <= cdb_miss;
                    ent_q[cdb_idx].target <= cdb_target;
                end
                if (alloc_fire) begin
                    valid_q[tail_q]    <= 1'b1;
                    done_q[tail_q]     <= 1'b0;
                    ent_q[tail_q].we   <= alloc_we;
                    ent_q[tail_q].rd   <= alloc_rd;
                    ent_q[tail_q].miss <= 1'b0;
                end
            end
        end
    end

    assign ROB_we    = rob_we_q;
    assign reg_addr  = reg_addr_q;
    assign reg_data  = reg_data_q;
    assign reg_tag   = reg_tag_q;
    assign br        = br_q;
    assign br_target = br_target_q;
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Bench for rob_commit_ctrl: operand-query vector table plus scoreboarded commit/flush sequences.
module tb_rob_commit_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_req, alloc_we;
    logic [4:0]  alloc_rd;
    logic        alloc_ok;
    logic [7:0]  alloc_tag;
    logic        cdb_valid, cdb_miss;
    logic [7:0]  cdb_tag;
    logic [31:0] cdb_data, cdb_target;
    logic [7:0]  q1_tag, q2_tag;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_data, q2_data;
    logic        rob_we, br;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data, br_target;
    logic [7:0]  reg_tag;

    always #5 clk = ~clk;

    rob_commit_ctrl #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst_n),
        .alloc_req(alloc_req), .alloc_we(alloc_we), .alloc_rd(alloc_rd),
        .alloc_ok(alloc_ok), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_miss(cdb_miss), .cdb_target(cdb_target),
        .q1_tag(q1_tag), .q2_tag(q2_tag),
        .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_data(q1_data), .q2_data(q2_data),
        .ROB_we(rob_we), .reg_addr(reg_addr), .reg_data(reg_data), .reg_tag(reg_tag),
        .br(br), .br_target(br_target)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [7:0]  tag;
    } cmt_t;

    typedef struct {
        logic        cv;
        logic [7:0]  ct;
        logic [31:0] cd;
        logic [7:0]  t1;
        logic [7:0]  t2;
        logic        r1;
        logic        c1;
        logic [31:0] d1;
        logic        r2;
        logic        c2;
        logic [31:0] d2;
    } vec_t;

    cmt_t        exp_q[$];
    logic [31:0] exp_br_q[$];
    vec_t        vt[9];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          we_cyc[256];
    int          br_cyc = 0;
    int          c;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every ROB_we / br pulse must match the oldest expected record.
    always @(negedge clk) begin
        cmt_t e;
        if (rst_n === 1'b1) begin
            if (rob_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_commit: got tag %0d rd %0d, expected no write", reg_tag, reg_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("commit_rd", 32'(reg_addr), 32'(e.rd));
                    check("commit_data", reg_data, e.data);
                    check("commit_tag", 32'(reg_tag), 32'(e.tag));
                    we_cyc[reg_tag] = cyc;
                end
            end
            if (br === 1'b1) begin
                if (exp_br_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_br: got target 0x%0h, expected no flush", br_target);
                end else begin
                    check("br_target", br_target, exp_br_q.pop_front());
                    br_cyc = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        alloc_req = 1'b0;
        cdb_valid = 1'b0;
        cdb_miss = 1'b0;
        q1_tag = 8'd1;
        q2_tag = 8'd8;
        #2;
        check("rst_rob_we", 32'(rob_we), 32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        check("rst_reg_data", reg_data, 32'd0);
        check("rst_reg_tag", 32'(reg_tag), 32'd0);
        check("rst_br", 32'(br), 32'd0);
        check("rst_br_target", br_target, 32'd0);
        check("rst_alloc_ok", 32'(alloc_ok), 32'd1);
        check("rst_alloc_tag", 32'(alloc_tag), 32'd1);
        check("rst_q1_ready", 32'(q1_ready), 32'd0);
        check("rst_q2_ready", 32'(q2_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        q1_tag = 8'd0;
        q2_tag = 8'd0;
    endtask

    task automatic do_alloc(input logic we, input logic [4:0] rd, input logic [7:0] etag);
        alloc_req = 1'b1;
        alloc_we = we;
        alloc_rd = rd;
        #1;
        check("alloc_ok", 32'(alloc_ok), 32'd1);
        check("alloc_tag", 32'(alloc_tag), 32'(etag));
        tick();
        alloc_req = 1'b0;
    endtask

    task automatic do_cdb(input logic [7:0] t, input logic [31:0] d, input logic m, input logic [31:0] tgt);
        cdb_valid = 1'b1;
        cdb_tag = t;
        cdb_data = d;
        cdb_miss = m;
        cdb_target = tgt;
        tick();
        cdb_valid = 1'b0;
        cdb_miss = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || exp_br_q.size() != 0) && i < 40) begin
            tick();
            i++;
        end
        repeat (3) tick();
        check(name, 32'(exp_q.size() + exp_br_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        alloc_req = 1'b0; alloc_we = 1'b0; alloc_rd = 5'd0;
        cdb_valid = 1'b0; cdb_tag = 8'd0; cdb_data = 32'd0; cdb_miss = 1'b0; cdb_target = 32'd0;
        q1_tag = 8'd0; q2_tag = 8'd0;

        // Entries 1..4 allocated, none done at row 0; entries 5..8 never allocated.
        vt[0] = '{1'b1, 8'd2, 32'h0000ABCD, 8'd2, 8'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0};
        vt[1] = '{1'b0, 8'd0, 32'h0,        8'd2, 8'd0, 1'b1, 1'b1, 32'h0000ABCD, 1'b0, 1'b1, 32'h0};
        vt[2] = '{1'b1, 8'd9, 32'h00000999, 8'd2, 8'd9, 1'b1, 1'b1, 32'h0000ABCD, 1'b0, 1'b1, 32'h0};
        vt[3] = '{1'b1, 8'd6, 32'h00000666, 8'd9, 8'd6, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0};
        vt[4] = '{1'b1, 8'd3, 32'h00000033, 8'd6, 8'd3, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        vt[5] = '{1'b1, 8'd2, 32'h00002222, 8'd3, 8'd2, 1'b1, 1'b1, 32'h33,       1'b1, 1'b1, 32'h0000ABCD};
        vt[6] = '{1'b0, 8'd0, 32'h0,        8'd2, 8'd4, 1'b1, 1'b1, 32'h00002222, 1'b0, 1'b0, 32'h0};
        vt[7] = '{1'b1, 8'd0, 32'h00000055, 8'd0, 8'd1, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0};
        vt[8] = '{1'b0, 8'd0, 32'h0,        8'd1, 8'd3, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h33};

        repeat (2) tick();
        do_reset();

        // In-order retirement despite out-of-order completion.
        do_alloc(1'b1, 5'd5, 8'd1);
        do_alloc(1'b1, 5'd6, 8'd2);
        do_alloc(1'b1, 5'd7, 8'd3);
        exp_q.push_back('{5'd5, 32'h11, 8'd1});
        exp_q.push_back('{5'd6, 32'h22, 8'd2});
        exp_q.push_back('{5'd7, 32'h33, 8'd3});
        do_cdb(8'd3, 32'h33, 1'b0, 32'd0);
        c = cyc;
        do_cdb(8'd1, 32'h11, 1'b0, 32'd0);
        do_cdb(8'd2, 32'h22, 1'b0, 32'd0);
        wait_drain("inorder_drain");
        check("inorder_latency", we_cyc[1], c + 2);
        check("inorder_tag2_cycle", we_cyc[2], c + 3);
        check("inorder_b2b_tag3", we_cyc[3], we_cyc[2] + 1);

        // Operand queries, ignored broadcasts, silent commits.
        do_reset();
        do_alloc(1'b1, 5'd5, 8'd1);
        do_alloc(1'b0, 5'd6, 8'd2);
        do_alloc(1'b1, 5'd0, 8'd3);
        do_alloc(1'b1, 5'd7, 8'd4);
        for (int i = 0; i < 9; i++) begin
            cdb_valid = vt[i].cv;
            cdb_tag = vt[i].ct;
            cdb_data = vt[i].cd;
            q1_tag = vt[i].t1;
            q2_tag = vt[i].t2;
            #1;
            check($sformatf("vec%0d_q1_ready", i), 32'(q1_ready), 32'(vt[i].r1));
            if (vt[i].c1) check($sformatf("vec%0d_q1_data", i), q1_data, vt[i].d1);
            check($sformatf("vec%0d_q2_ready", i), 32'(q2_ready), 32'(vt[i].r2));
            if (vt[i].c2) check($sformatf("vec%0d_q2_data", i), q2_data, vt[i].d2);
            tick();
        end
        cdb_valid = 1'b0;
        q1_tag = 8'd0;
        q2_tag = 8'd0;
        exp_q.push_back('{5'd5, 32'h11, 8'd1});
        exp_q.push_back('{5'd7, 32'h44, 8'd4});
        c = cyc;
        do_cdb(8'd1, 32'h11, 1'b0, 32'd0);
        tick();
        tick();
        check("nowe_rob_we", 32'(rob_we), 32'd0);
        check("nowe_reg_tag", 32'(reg_tag), 32'd2);
        check("nowe_reg_addr", 32'(reg_addr), 32'd6);
        check("nowe_reg_data", reg_data, 32'h2222);
        tick();
        check("rd0_rob_we", 32'(rob_we), 32'd0);
        check("rd0_reg_tag", 32'(reg_tag), 32'd3);
        check("rd0_reg_data", reg_data, 32'h33);
        do_cdb(8'd4, 32'h44, 1'b0, 32'd0);
        wait_drain("edge_drain");
        check("edge_latency", we_cyc[1], c + 2);

        // Full ROB and tail wrap.
        do_reset();
        for (int i = 0; i < 8; i++) do_alloc(1'b1, 5'(8 + i), 8'(i + 1));
        #1;
        check("full_alloc_ok", 32'(alloc_ok), 32'd0);
        check("full_alloc_tag", 32'(alloc_tag), 32'd1);
        exp_q.push_back('{5'd8, 32'hF1, 8'd1});
        alloc_req = 1'b1;
        alloc_we = 1'b1;
        alloc_rd = 5'd20;
        do_cdb(8'd1, 32'hF1, 1'b0, 32'd0);
        #1;
        check("full_commit_alloc_ok", 32'(alloc_ok), 32'd0);
        tick();
        #1;
        check("wrap_alloc_ok", 32'(alloc_ok), 32'd1);
        check("wrap_alloc_tag", 32'(alloc_tag), 32'd1);
        tick();
        alloc_req = 1'b0;
        #1;
        check("refull_alloc_ok", 32'(alloc_ok), 32'd0);
        check("refull_alloc_tag", 32'(alloc_tag), 32'd2);
        wait_drain("full_drain");

        // Mispredict flush, with reset issued above while entries were in flight.
        do_reset();
        for (int i = 0; i < 4; i++) do_alloc(1'b1, 5'(i + 1), 8'(i + 1));
        exp_q.push_back('{5'd1, 32'h111, 8'd1});
        exp_q.push_back('{5'd2, 32'h222, 8'd2});
        exp_br_q.push_back(32'h200);
        do_cdb(8'd3, 32'h333, 1'b0, 32'd0);
        do_cdb(8'd4, 32'h444, 1'b0, 32'd0);
        do_cdb(8'd2, 32'h222, 1'b1, 32'h200);
        do_cdb(8'd1, 32'h111, 1'b0, 32'd0);
        tick();
        alloc_req = 1'b1;
        alloc_we = 1'b1;
        alloc_rd = 5'd9;
        cdb_valid = 1'b1;
        cdb_tag = 8'd3;
        cdb_data = 32'hBAD;
        #1;
        check("flush_alloc_ok", 32'(alloc_ok), 32'd0);
        tick();
        alloc_req = 1'b0;
        cdb_valid = 1'b0;
        q1_tag = 8'd3;
        q2_tag = 8'd1;
        #1;
        check("post_flush_alloc_tag", 32'(alloc_tag), 32'd1);
        check("post_flush_alloc_ok", 32'(alloc_ok), 32'd1);
        check("post_flush_q1_ready", 32'(q1_ready), 32'd0);
        check("post_flush_q2_ready", 32'(q2_ready), 32'd0);
        q1_tag = 8'd0;
        q2_tag = 8'd0;
        tick();
        check("br_with_branch_commit", br_cyc, we_cyc[2]);
        check("br_pulse_end", 32'(br), 32'd0);
        exp_q.push_back('{5'd9, 32'h777, 8'd1});
        do_alloc(1'b1, 5'd9, 8'd1);
        do_cdb(8'd1, 32'h777, 1'b0, 32'd0);
        wait_drain("flush_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rob_commit_ctrl.md
# rob_commit_ctrl

Reorder-buffer controller for the Tomasulo core. It allocates rename tags to the decoder, collects results from the common data bus (CDB), and retires entries strictly in program order. Each retirement drives the register file's ROB write port (`ROB_we`/`reg_addr`/`reg_data`/`reg_tag`). A mispredicted branch raises `br` at retirement, which flushes every in-flight entry and all register locks.

## Interface
- `DEPTH`, default 8: number of ROB entries, 2..255; tags are 1..DEPTH, and tag 0 means "unlocked".
- `clk`  input  1  clock, all state on rising edge
- `rst`  input  1  asynchronous, active-low reset
- `alloc_req`  input  1  decoder requests an entry this cycle
- `alloc_we`  input  1  instruction writes a destination register
- `alloc_rd`  input  5  destination register
- `alloc_ok`  output  1  combinational grant; the entry is taken at the clock edge when `alloc_req && alloc_ok`
- `alloc_tag`  output  8  combinational tag of the tail entry, equal to tail index+1; drives the register file's `reg_wtag`
- `cdb_valid`  input  1  completion broadcast
- `cdb_tag`  input  8  tag of the completing entry
- `cdb_data`  input  32  result value
- `cdb_miss`  input  1  completing branch was mispredicted
- `cdb_target`  input  32  correct PC for a mispredicted branch
- `q1_tag`, `q2_tag`  input  8  operand tags from the register file's `lock1`/`lock2`
- `q1_ready`, `q2_ready`  output  1  combinational: the tagged entry is valid and done
- `q1_data`, `q2_data`  output  32  combinational: value of the tagged entry
- `ROB_we`  output  1  registered commit-write pulse
- `reg_addr`  output  5  registered commit destination
- `reg_data`  output  32  registered commit value
- `reg_tag`  output  8  registered tag of the committed entry
- `br`  output  1  registered one-cycle flush pulse
- `br_target`  output  32  registered redirect PC, valid while `br`=1

## Operation
- Per-entry state: `valid`, `done`, `we`, `rd[4:0]`, `data[31:0]`, `miss`, `target[31:0]`.
- Control state: `head`, `tail`, `count` (0..DEPTH); pointers wrap from DEPTH-1 to 0.
- `commit` = `entry[head].valid && entry[head].done`.
- `flush` = `commit && entry[head].miss`.
- `alloc_ok` = `(count < DEPTH) && !flush`. A slot freed by a same-cycle commit is not reusable until the next cycle.
- Allocate: write `valid=1, done=0, we=alloc_we, rd=alloc_rd, miss=0` at `tail`, then advance `tail`.
- CDB: if `cdb_valid`, `1 <= cdb_tag <= DEPTH` and the entry at `cdb_tag-1` is valid, store `data`, `miss`, `target` and set `done`. Otherwise ignore the broadcast. A CDB to an already-done entry overwrites its value.
- Commit without flush:
  - `ROB_we <= we && rd!=0`; `reg_addr <= rd`; `reg_data <= data`; `reg_tag <= head+1`.
  - Clear `valid`, advance `head`, decrement `count`.
  - `count` is unchanged when an allocate and a commit happen in the same cycle.
- Commit with flush:
  - Drive the same register write as a normal commit (e.g. `jal` writing `rd`).
  - Also `br <= 1`, `br_target <= target`.
  - Clear every `valid`; `head <= 0`, `tail <= 0`, `count <= 0`.
  - The CDB and any allocate request in that cycle are discarded.
- Operand query `qN`: the tag is valid when `1 <= tag <= DEPTH` and the entry is valid.
  - `qN_ready` = entry valid && done; `qN_data` = entry data.
  - Tag 0 or out of range: `qN_ready=0`, `qN_data=0`.
  - No bypass from a same-cycle CDB; the value is visible the cycle after capture.
- Arithmetic: pointers are `$clog2(DEPTH)` bits and wrap explicitly at DEPTH; `count` is one bit wider.

## Timing
- Reset (`rst`=0, asynchronous): all entries invalid; `head=tail=count=0`; `ROB_we=0`, `reg_addr=0`, `reg_data=0`, `reg_tag=0`, `br=0`, `br_target=0`. The combinational outputs settle to `alloc_ok=1`, `alloc_tag=1`, `q*_ready=0`. Reset mid-operation drops all in-flight entries.
- `ROB_we` and `br` are single-cycle pulses. They deassert on the next edge unless that edge commits again.
- Latency: a CDB at edge N sets `done`; the commit registers at edge N+1 (if the entry is at the head); `ROB_we` is high during cycle N+1..N+2.
- Throughput: at most one allocate, one CDB capture and one commit per cycle.
- Full (`count==DEPTH`): `alloc_ok=0` even if a commit happens the same cycle.
- Empty: no commit; all `ROB_we`/`br` pulses end.
- After a flush, the first allocate receives tag 1.

## Test plan
- Reset: hold `rst`=0 → all registered outputs 0, `alloc_ok=1`, `alloc_tag=1`; release → first allocate of `rd`=5 receives tag 1.
- In-order retire: allocate tags 1,2,3 (rd 5,6,7); CDB tag 3 (data 0x33), then tag 1 (0x11), then tag 2 (0x22) → `ROB_we` pulses in order (5,0x11,tag1), (6,0x22,tag2), (7,0x33,tag3), with tags 2 and 3 retiring on back-to-back cycles.
- Full/wrap: with `DEPTH`=8, allocate 8 entries → `alloc_ok=0`; retire tag 1 → a new allocate receives tag 1 (wrap), and `count` returns to 8.
- Mispredict: allocate tags 1..4; CDB tag 2 with `cdb_miss=1`, `cdb_target=0x200`; complete tag 1 → tag 1 commits, then `br=1`, `br_target=0x200` for one cycle; tags 3 and 4 never commit; the next allocate gets tag 1.
- Query: CDB tag 2 with 0xABCD → same cycle `q1_tag=2` gives `q1_ready=0`; next cycle `q1_ready=1`, `q1_data=0xABCD`; `q1_tag=0` gives `ready=0`, `data=0`.
- Edge cases: `alloc_we=0` entry and `rd=0` entry commit with `ROB_we=0`; CDB to an unallocated tag or tag 9 has no effect.
